// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the decode-side hazard inputs and the hazard controller's
//   pipeline-control outputs for the 5-stage 16-bit core.
//   master : decode / pipeline side (drives ID info, consumes controls)
//   slave  : hazard_ctrl
//   Signals:
//     id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regwrite,
//     id_memread, id_flagwrite, id_flagread, id_br_taken   (master -> slave)
//     stall, bubble_ex, flush_ifid, forward_aluin1, forward_aluin2,
//     flag_en, stall_cnt                                   (slave -> master)
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_rs;
    logic [3:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [3:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_flagwrite;
    logic             id_flagread;
    logic             id_br_taken;

    logic             stall;
    logic             bubble_ex;
    logic             flush_ifid;
    logic [1:0]       forward_aluin1;
    logic [1:0]       forward_aluin2;
    logic             flag_en;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_regwrite, id_memread, id_flagwrite, id_flagread, id_br_taken,
        input  stall, bubble_ex, flush_ifid, forward_aluin1, forward_aluin2,
               flag_en, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_regwrite, id_memread, id_flagwrite, id_flagread, id_br_taken,
        output stall, bubble_ex, flush_ifid, forward_aluin1, forward_aluin2,
               flag_en, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. Keeps a shadow copy of the destination and
//   flag-write info of the instructions in EX/MEM/WB, detects load-use and
//   flag-use hazards against the instruction in ID, selects EX operand
//   forwarding and counts stall cycles (saturating).
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     hz   - hazard_ctrl_if.slave: ID inputs in, stall/bubble/flush,
//            forwarding selects, flag_en and stall_cnt out
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_if.slave   hz
);
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [3:0] rd;
        logic       memread;
        logic       flagwrite;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       use_rs;
        logic       use_rt;
    } ex_rec_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [3:0] rd;
        logic       memread;
        logic       flagwrite;
    } pipe_rec_t;

    ex_rec_t          ex_q, ex_d;
    pipe_rec_t        mem_q, mem_d;
    pipe_rec_t        wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             load_use;
    logic             flag_use;
    logic             stall;

    // Load/flag bits are carried into WB for completeness but nothing
    // downstream of WB consumes them.
    logic             unused_wb_bits;
    assign unused_wb_bits = wb_q.memread ^ wb_q.flagwrite;

    always_comb begin
        load_use = ex_q.valid & ex_q.memread & ex_q.regwrite & (ex_q.rd != 4'd0) &
                   ((hz.id_use_rs & (hz.id_rs == ex_q.rd)) |
                    (hz.id_use_rt & (hz.id_rt == ex_q.rd)));
        flag_use = hz.id_flagread & ex_q.valid & ex_q.flagwrite;
        stall    = hz.id_valid & (load_use | flag_use);
    end

    // Youngest producer wins. A load sitting in MEM is skipped: the load-use
    // stall guarantees its consumer only reaches EX once the load is in WB.
    function automatic logic [1:0] fwd_sel(input logic use_x, input logic [3:0] x);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_x && (x != 4'd0)) begin
            if (mem_q.valid && mem_q.regwrite && !mem_q.memread && (mem_q.rd == x))
                sel = 2'b01;
            else if (wb_q.valid && wb_q.regwrite && (wb_q.rd == x))
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        ex_d = ex_q;
        if (stall) begin
            ex_d.valid = 1'b0;
        end else begin
            ex_d.valid     = hz.id_valid;
            ex_d.regwrite  = hz.id_regwrite;
            ex_d.rd        = hz.id_rd;
            ex_d.memread   = hz.id_memread;
            ex_d.flagwrite = hz.id_flagwrite;
            ex_d.rs        = hz.id_rs;
            ex_d.rt        = hz.id_rt;
            ex_d.use_rs    = hz.id_use_rs;
            ex_d.use_rt    = hz.id_use_rt;
        end

        mem_d.valid     = ex_q.valid;
        mem_d.regwrite  = ex_q.regwrite;
        mem_d.rd        = ex_q.rd;
        mem_d.memread   = ex_q.memread;
        mem_d.flagwrite = ex_q.flagwrite;

        wb_d = mem_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall          = stall;
    assign hz.bubble_ex      = stall;
    assign hz.flush_ifid     = hz.id_br_taken & ~stall;
    assign hz.forward_aluin1 = fwd_sel(ex_q.use_rs, ex_q.rs);
    assign hz.forward_aluin2 = fwd_sel(ex_q.use_rt, ex_q.rt);
    assign hz.flag_en        = ex_q.valid & ex_q.flagwrite;
    assign hz.stall_cnt      = stall_cnt_q;
endmodule
